// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life engine: FSM states,
// neighbour visit order, LFSR seed/taps and the birth/survival rule.
package gol_pkg;

  typedef enum logic [2:0] {IDLE, INIT, CLEAR, UPDATE, COPY} gol_state_e;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  // Feedback taps b15, b13, b12, b10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Neighbour visit order, one entry per accumulate cycle
  localparam int NB_COUNT = 8;
  localparam int NB_DX [NB_COUNT] = '{-1, 0, 1, -1, 1, -1,  0,  1};
  localparam int NB_DY [NB_COUNT] = '{ 1, 1, 1,  0, 0, -1, -1, -1};

  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (alive && (n == 4'd2)) || (n == 4'd3);
  endfunction

endpackage

// File: rtl/gol_if.sv
// Control, host-write, display-read and status signals of the Game of Life
// engine; the host/top-level side is the master, the engine the slave.
interface gol_if #(
  parameter int LOG_W = 6,
  parameter int LOG_H = 5,
  parameter int GEN_W = 16
) ();

  logic                   run;
  logic                   frame_sync;
  logic                   step_req;
  logic                   rand_req;
  logic                   clear_req;
  logic                   wrap_mode;
  logic                   wr_en;
  logic [LOG_W-1:0]       wr_x;
  logic [LOG_H-1:0]       wr_y;
  logic                   wr_data;
  logic [LOG_W-1:0]       rd_x;
  logic [LOG_H-1:0]       rd_y;
  logic                   rd_cell;
  logic                   busy;
  logic                   done;
  logic [GEN_W-1:0]       gen_count;
  logic [LOG_W+LOG_H:0]   pop_count;

  modport master (
    output run, frame_sync, step_req, rand_req, clear_req, wrap_mode,
           wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    input  rd_cell, busy, done, gen_count, pop_count
  );

  modport slave (
    input  run, frame_sync, step_req, rand_req, clear_req, wrap_mode,
           wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    output rd_cell, busy, done, gen_count, pop_count
  );

endinterface

// File: rtl/gol_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (shift left) used to seed random boards.
module gol_lfsr
  import gol_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic bit_out
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/gol_engine.sv
// Sequential Game of Life engine: one cell per cycle for init/clear/copy and
// nine cycles per cell (8 neighbour reads + 1 write) for a generation update.
module gol_engine
  import gol_pkg::*;
#(
  parameter int LOG_W           = 6,
  parameter int LOG_H           = 5,
  parameter int UPDATE_INTERVAL = 2400000,
  parameter int RESET_INIT      = 1,
  parameter int GEN_W           = 16
) (
  input  logic clk,
  input  logic reset,
  gol_if.slave bus
);

  localparam int IW = LOG_W + LOG_H;
  localparam int N  = 1 << IW;
  localparam int PW = IW + 1;
  localparam int TW = $clog2(UPDATE_INTERVAL + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(UPDATE_INTERVAL - 1);
  localparam gol_state_e RESET_STATE = (RESET_INIT != 0) ? INIT : CLEAR;

  gol_state_e        state;
  logic [IW-1:0]     idx;
  logic [3:0]        phase;
  logic [3:0]        acc;
  logic [PW-1:0]     pop_acc;
  logic [TW-1:0]     timer;
  logic              wrap_q;
  logic              done_q;
  logic [GEN_W-1:0]  gen_q;
  logic [PW-1:0]     pop_q;

  logic [N-1:0]      board;
  logic [N-1:0]      board_next;

  logic              lfsr_bit;
  logic [LOG_W-1:0]  cx;
  logic [LOG_H-1:0]  cy;
  logic [LOG_W-1:0]  nx;
  logic [LOG_H-1:0]  ny;
  int                dx;
  int                dy;
  logic              x_out;
  logic              y_out;
  logic              nb_alive;
  logic              next_alive;
  logic [PW-1:0]     pop_sum;
  logic              timer_hit;
  logic              req_any;
  logic              host_wr_ok;

  gol_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .bit_out (lfsr_bit)
  );

  assign cx = idx[LOG_W-1:0];
  assign cy = idx[IW-1:LOG_W];

  // Neighbour for the current accumulate phase; modular add gives the torus,
  // the edge flags mask it out in dead-boundary mode.
  always_comb begin
    dx       = NB_DX[phase[2:0]];
    dy       = NB_DY[phase[2:0]];
    nx       = cx + LOG_W'(dx);
    ny       = cy + LOG_H'(dy);
    x_out    = ((dx < 0) && (cx == '0)) || ((dx > 0) && (&cx));
    y_out    = ((dy < 0) && (cy == '0)) || ((dy > 0) && (&cy));
    nb_alive = board[{ny, nx}] & (wrap_q | ~(x_out | y_out));
  end

  assign next_alive = life_rule(board[idx], acc);
  assign pop_sum    = pop_acc + PW'(next_alive);

  assign timer_hit  = bus.run && bus.frame_sync && (timer == TIMER_MAX);
  assign req_any    = bus.clear_req || bus.rand_req || bus.step_req || timer_hit;
  assign host_wr_ok = (state == IDLE) && !req_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      idx     <= '0;
      phase   <= '0;
      acc     <= '0;
      pop_acc <= '0;
      timer   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      gen_q   <= '0;
      pop_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Only the highest-priority request is taken; the rest are dropped
          if (bus.clear_req) begin
            state <= CLEAR;
            idx   <= '0;
            timer <= '0;
          end else if (bus.rand_req) begin
            state <= INIT;
            idx   <= '0;
            timer <= '0;
          end else if (bus.step_req || timer_hit) begin
            state   <= UPDATE;
            idx     <= '0;
            phase   <= '0;
            acc     <= '0;
            pop_acc <= '0;
            wrap_q  <= bus.wrap_mode;
            timer   <= '0;
          end else if (bus.run && (timer != TIMER_MAX)) begin
            timer <= timer + 1'b1;
          end
        end
        INIT, CLEAR: begin
          idx <= idx + 1'b1;
          if (&idx) begin
            state  <= IDLE;
            done_q <= 1'b1;
            gen_q  <= '0;
          end
        end
        UPDATE: begin
          if (phase == 4'd8) begin
            phase <= '0;
            acc   <= '0;
            idx   <= idx + 1'b1;
            if (&idx) begin
              pop_q   <= pop_sum;
              pop_acc <= '0;
              state   <= COPY;
            end else begin
              pop_acc <= pop_sum;
            end
          end else begin
            acc   <= acc + {3'b000, nb_alive};
            phase <= phase + 4'd1;
          end
        end
        COPY: begin
          idx <= idx + 1'b1;
          if (&idx) begin
            state  <= IDLE;
            done_q <= 1'b1;
            gen_q  <= gen_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cell storage carries no reset; contents are rebuilt by INIT/CLEAR
  always_ff @(posedge clk) begin
    case (state)
      INIT:  board[idx] <= lfsr_bit;
      CLEAR: board[idx] <= 1'b0;
      COPY:  board[idx] <= board_next[idx];
      IDLE: begin
        if (host_wr_ok && bus.wr_en) begin
          board[{bus.wr_y, bus.wr_x}] <= bus.wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((state == UPDATE) && (phase == 4'd8)) begin
      board_next[idx] <= next_alive;
    end
  end

  assign bus.rd_cell   = board[{bus.rd_y, bus.rd_x}];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.gen_count = gen_q;
  assign bus.pop_count = pop_q;

endmodule

// File: tb/tb_gol_engine.sv
// Self-checking bench for gol_engine on an 8x8 board, comparing against a
// cell-array model of the Life rules and an LFSR sequence model.
module tb_gol_engine;

  localparam int LW = 3;
  localparam int LH = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = 64;
  localparam int GW = 16;
  localparam int UI = 10;

  logic clk = 1'b0;
  logic reset;
  logic reset_r;

  int checks = 0;
  int passes = 0;

  bit mdl  [H][W];
  bit dutb [H][W];
  bit dutr [H][W];
  bit lexp [N];
  int mgen;

  gol_if #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW)) bus ();
  gol_if #(.LOG_W(LW), .LOG_H(LH), .GEN_W(GW)) bus_r ();

  gol_engine #(.LOG_W(LW), .LOG_H(LH), .UPDATE_INTERVAL(UI), .RESET_INIT(0), .GEN_W(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  gol_engine #(.LOG_W(LW), .LOG_H(LH), .UPDATE_INTERVAL(UI), .RESET_INIT(1), .GEN_W(GW)) dut_r (
    .clk   (clk),
    .reset (reset_r),
    .bus   (bus_r)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int count_nb(int x, int y, bit wrap);
    int n = 0;
    for (int ddy = -1; ddy <= 1; ddy++) begin
      for (int ddx = -1; ddx <= 1; ddx++) begin
        int px = x + ddx;
        int py = y + ddy;
        if (ddx == 0 && ddy == 0) continue;
        if (wrap) begin
          px = (px + W) % W;
          py = (py + H) % H;
        end else if (px < 0 || px >= W || py < 0 || py >= H) begin
          continue;
        end
        n += int'(mdl[py][px]);
      end
    end
    return n;
  endfunction

  task automatic model_step(input bit wrap);
    bit nxt [H][W];
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n = count_nb(x, y, wrap);
        nxt[y][x] = (n == 3) || (mdl[y][x] && n == 2);
      end
    mdl  = nxt;
    mgen = mgen + 1;
  endtask

  function automatic int model_pop();
    int p = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) p += int'(mdl[y][x]);
    return p;
  endfunction

  function automatic int board_diff();
    int d = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) if (dutb[y][x] != mdl[y][x]) d++;
    return d;
  endfunction

  function automatic int init_diff();
    int d = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) if (dutr[y][x] != lexp[y*W + x]) d++;
    return d;
  endfunction

  task automatic build_lfsr_model();
    logic [15:0] s = 16'h0001;
    for (int i = 0; i < N; i++) begin
      lexp[i] = s[0];
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
  endtask

  task automatic model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mdl[y][x] = 1'b0;
    mgen = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    bus.run = 0; bus.frame_sync = 0; bus.step_req = 0; bus.rand_req = 0;
    bus.clear_req = 0; bus.wrap_mode = 0; bus.wr_en = 0; bus.wr_x = '0;
    bus.wr_y = '0; bus.wr_data = 0; bus.rd_x = '0; bus.rd_y = '0;
    bus_r.run = 0; bus_r.frame_sync = 0; bus_r.step_req = 0; bus_r.rand_req = 0;
    bus_r.clear_req = 0; bus_r.wrap_mode = 0; bus_r.wr_en = 0; bus_r.wr_x = '0;
    bus_r.wr_y = '0; bus_r.wr_data = 0; bus_r.rd_x = '0; bus_r.rd_y = '0;
  endtask

  task automatic read_boards();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus.rd_x = LW'(x);   bus.rd_y = LH'(y);
        bus_r.rd_x = LW'(x); bus_r.rd_y = LH'(y);
        #1;
        dutb[y][x] = bus.rd_cell;
        dutr[y][x] = bus_r.rd_cell;
      end
  endtask

  task automatic write_cell(input int x, input int y, input bit v);
    @(negedge clk);
    bus.wr_en = 1; bus.wr_x = LW'(x); bus.wr_y = LH'(y); bus.wr_data = v;
    @(negedge clk);
    bus.wr_en = 0;
    mdl[y][x] = v;
  endtask

  task automatic issue(input bit which, input bit c, input bit r, input bit s, input bit w);
    @(negedge clk);
    if (which) begin
      bus_r.clear_req = c; bus_r.rand_req = r; bus_r.step_req = s; bus_r.wrap_mode = w;
    end else begin
      bus.clear_req = c; bus.rand_req = r; bus.step_req = s; bus.wrap_mode = w;
    end
    @(posedge clk);
    #1;
    bus.clear_req = 0; bus.rand_req = 0; bus.step_req = 0;
    bus_r.clear_req = 0; bus_r.rand_req = 0; bus_r.step_req = 0;
  endtask

  task automatic wait_done(input bit which, output int cyc);
    bit got = 0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      got = which ? bus_r.done : bus.done;
    end
    if (!got) cyc = -1;
  endtask

  task automatic clear_all();
    int cyc;
    issue(0, 1, 0, 0, 0);
    wait_done(0, cyc);
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    drive_idle();
    reset = 1; reset_r = 1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL reset_busy: got %0b want 1", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", bus.done); else passes++;
    reset = 0; reset_r = 0;
    wait_done(0, cyc);
    checks++; if (cyc != N) $display("[TB] FAIL reset_clear_len: got %0d want %0d", cyc, N); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_idle: got %0b want 0", bus.busy); else passes++;
    checks++; if (bus.gen_count !== GW'(0)) $display("[TB] FAIL reset_gen: got %0d want 0", bus.gen_count); else passes++;
    checks++; if (bus.pop_count !== 7'd0) $display("[TB] FAIL reset_pop: got %0d want 0", bus.pop_count); else passes++;
    model_clear();
    read_boards();
    checks++; if (board_diff() != 0) $display("[TB] FAIL reset_board: got %0d wrong cells want 0", board_diff()); else passes++;
    build_lfsr_model();
    checks++; if (init_diff() != 0) $display("[TB] FAIL reset_init_board: got %0d wrong cells want 0", init_diff()); else passes++;
  endtask

  task automatic test_blinker();
    int cyc;
    write_cell(3, 2, 1); write_cell(3, 3, 1); write_cell(3, 4, 1);
    issue(0, 0, 0, 1, 1);
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL blinker_busy: got %0b want 1", bus.busy); else passes++;
    wait_done(0, cyc);
    checks++; if (cyc != 10*N) $display("[TB] FAIL blinker_latency: got %0d want %0d", cyc, 10*N); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL blinker_done_pulse: got %0b want 0", bus.done); else passes++;
    model_step(1);
    read_boards();
    checks++; if (board_diff() != 0) $display("[TB] FAIL blinker_board1: got %0d wrong cells want 0", board_diff()); else passes++;
    checks++; if (!(dutb[3][2] && dutb[3][3] && dutb[3][4])) $display("[TB] FAIL blinker_row: got %0b%0b%0b want 111", dutb[3][2], dutb[3][3], dutb[3][4]); else passes++;
    checks++; if (bus.pop_count !== 7'd3) $display("[TB] FAIL blinker_pop: got %0d want 3", bus.pop_count); else passes++;
    checks++; if (bus.gen_count !== GW'(1)) $display("[TB] FAIL blinker_gen1: got %0d want 1", bus.gen_count); else passes++;
    issue(0, 0, 0, 1, 1);
    wait_done(0, cyc);
    model_step(1);
    read_boards();
    checks++; if (board_diff() != 0) $display("[TB] FAIL blinker_board2: got %0d wrong cells want 0", board_diff()); else passes++;
    checks++; if (bus.gen_count !== GW'(2)) $display("[TB] FAIL blinker_gen2: got %0d want 2", bus.gen_count); else passes++;
  endtask

  task automatic test_corner();
    int cyc;
    clear_all();
    write_cell(0, 0, 1); write_cell(7, 0, 1); write_cell(0, 7, 1);
    issue(0, 0, 0, 1, 1);
    wait_done(0, cyc);
    model_step(1);
    read_boards();
    checks++; if (bus.pop_count !== 7'd4) $display("[TB] FAIL corner_wrap_pop: got %0d want 4", bus.pop_count); else passes++;
    checks++; if (dutb[7][7] !== 1'b1) $display("[TB] FAIL corner_wrap_birth: got %0b want 1", dutb[7][7]); else passes++;
    checks++; if (board_diff() != 0) $display("[TB] FAIL corner_wrap_board: got %0d wrong cells want 0", board_diff()); else passes++;
    clear_all();
    write_cell(0, 0, 1); write_cell(7, 0, 1); write_cell(0, 7, 1);
    issue(0, 0, 0, 1, 0);
    wait_done(0, cyc);
    model_step(0);
    read_boards();
    checks++; if (bus.pop_count !== 7'd0) $display("[TB] FAIL corner_dead_pop: got %0d want 0", bus.pop_count); else passes++;
    checks++; if (board_diff() != 0) $display("[TB] FAIL corner_dead_board: got %0d wrong cells want 0", board_diff()); else passes++;
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 4; it++) begin
      bit w = bit'(it % 2);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) write_cell(x, y, bit'($urandom_range(0, 1)));
      issue(0, 0, 0, 1, w);
      wait_done(0, cyc);
      model_step(w);
      read_boards();
      checks++; if (cyc != 10*N) $display("[TB] FAIL random_latency[%0d]: got %0d want %0d", it, cyc, 10*N); else passes++;
      checks++; if (board_diff() != 0) $display("[TB] FAIL random_board[%0d]: got %0d wrong cells want 0", it, board_diff()); else passes++;
      checks++; if (bus.pop_count !== 7'(model_pop())) $display("[TB] FAIL random_pop[%0d]: got %0d want %0d", it, bus.pop_count, model_pop()); else passes++;
      checks++; if (bus.gen_count !== GW'(mgen)) $display("[TB] FAIL random_gen[%0d]: got %0d want %0d", it, bus.gen_count, mgen); else passes++;
    end
  endtask

  task automatic test_priority();
    int cyc;
    write_cell(1, 1, 1); write_cell(2, 5, 1); write_cell(6, 3, 1);
    issue(0, 1, 1, 1, 1);
    wait_done(0, cyc);
    model_clear();
    read_boards();
    checks++; if (cyc != N) $display("[TB] FAIL prio_clear_len: got %0d want %0d", cyc, N); else passes++;
    checks++; if (board_diff() != 0) $display("[TB] FAIL prio_clear_board: got %0d wrong cells want 0", board_diff()); else passes++;
    checks++; if (bus.gen_count !== GW'(0)) $display("[TB] FAIL prio_clear_gen: got %0d want 0", bus.gen_count); else passes++;
    issue(0, 0, 1, 1, 1);
    wait_done(0, cyc);
    checks++; if (cyc != N) $display("[TB] FAIL prio_rand_len: got %0d want %0d", cyc, N); else passes++;
    clear_all();
    // write coinciding with a winning request, then a write while busy
    @(negedge clk);
    bus.step_req = 1; bus.wrap_mode = 1;
    bus.wr_en = 1; bus.wr_x = 3'd5; bus.wr_y = 3'd5; bus.wr_data = 1;
    @(posedge clk); #1;
    bus.step_req = 0; bus.wr_en = 0;
    repeat (5) @(negedge clk);
    bus.wr_en = 1; bus.wr_x = 3'd6; bus.wr_y = 3'd6; bus.wr_data = 1;
    @(negedge clk);
    bus.wr_en = 0;
    wait_done(0, cyc);
    model_step(1);
    read_boards();
    checks++; if (dutb[5][5] !== 1'b0) $display("[TB] FAIL prio_write_on_req: got %0b want 0", dutb[5][5]); else passes++;
    checks++; if (dutb[6][6] !== 1'b0) $display("[TB] FAIL busy_write_ignored: got %0b want 0", dutb[6][6]); else passes++;
    checks++; if (board_diff() != 0) $display("[TB] FAIL busy_write_board: got %0d wrong cells want 0", board_diff()); else passes++;
  endtask

  task automatic test_autorun();
    int cyc;
    bit seen_busy = 0;
    clear_all();
    write_cell(4, 1, 1); write_cell(4, 2, 1); write_cell(4, 3, 1);
    @(negedge clk);
    bus.run = 1; bus.frame_sync = 0; bus.wrap_mode = 1;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.busy) seen_busy = 1;
    end
    checks++; if (seen_busy) $display("[TB] FAIL auto_no_sync: got launch want none"); else passes++;
    @(negedge clk);
    bus.frame_sync = 1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL auto_launch: got %0b want 1", bus.busy); else passes++;
    bus.frame_sync = 0; bus.run = 0;
    wait_done(0, cyc);
    model_step(1);
    read_boards();
    checks++; if (cyc != 10*N) $display("[TB] FAIL auto_latency: got %0d want %0d", cyc, 10*N); else passes++;
    checks++; if (board_diff() != 0) $display("[TB] FAIL auto_board: got %0d wrong cells want 0", board_diff()); else passes++;
    seen_busy = 0;
    bus.frame_sync = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.busy) seen_busy = 1;
    end
    bus.frame_sync = 0;
    checks++; if (seen_busy) $display("[TB] FAIL auto_run_off: got launch want none"); else passes++;
    checks++; if (bus.gen_count !== GW'(1)) $display("[TB] FAIL auto_gen: got %0d want 1", bus.gen_count); else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    issue(1, 0, 0, 1, 1);
    wait_done(1, cyc);
    checks++; if (bus_r.gen_count !== GW'(1)) $display("[TB] FAIL mid_pre_gen: got %0d want 1", bus_r.gen_count); else passes++;
    issue(1, 0, 0, 1, 1);
    repeat (182) @(posedge clk);
    @(negedge clk);
    reset_r = 1;
    #1;
    checks++; if (bus_r.busy !== 1'b1) $display("[TB] FAIL mid_busy: got %0b want 1", bus_r.busy); else passes++;
    checks++; if (bus_r.done !== 1'b0) $display("[TB] FAIL mid_done: got %0b want 0", bus_r.done); else passes++;
    checks++; if (bus_r.gen_count !== GW'(0)) $display("[TB] FAIL mid_gen: got %0d want 0", bus_r.gen_count); else passes++;
    checks++; if (bus_r.pop_count !== 7'd0) $display("[TB] FAIL mid_pop: got %0d want 0", bus_r.pop_count); else passes++;
    repeat (2) @(negedge clk);
    reset_r = 0;
    wait_done(1, cyc);
    checks++; if (cyc != N) $display("[TB] FAIL mid_init_len: got %0d want %0d", cyc, N); else passes++;
    checks++; if (bus_r.busy !== 1'b0) $display("[TB] FAIL mid_idle: got %0b want 0", bus_r.busy); else passes++;
    read_boards();
    checks++; if (init_diff() != 0) $display("[TB] FAIL mid_init_board: got %0d wrong cells want 0", init_diff()); else passes++;
  endtask

  initial begin
    mgen = 0;
    test_reset();
    test_blinker();
    test_corner();
    test_random();
    test_priority();
    test_autorun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gol_engine.md
Name: gol_engine

Overview:
Parametrised Conway's Game of Life core: holds a 2^LOG_W x 2^LOG_H single-bit board and computes generations sequentially. Supports selectable toroidal or dead-boundary edges, single-step, clear, randomize and host cell writes. Reports generation and population counts. Sits between the VGA pixel path (combinational cell read port) and the top-level control inputs; replaces the fixed 64x32 free-running engine.

Parameters:
LOG_W, 6, log2 of board width in cells
LOG_H, 5, log2 of board height in cells
UPDATE_INTERVAL, 2400000, clk cycles between auto-steps while run=1
RESET_INIT, 1, post-reset action: 1 = randomize, 0 = clear
GEN_W, 16, width of generation counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
run  in  1  enable timer-driven auto-stepping
frame_sync  in  1  auto-step launches only while high (vsync)
step_req  in  1  level/pulse; request one generation
rand_req  in  1  request board randomize
clear_req  in  1  request board clear
wrap_mode  in  1  1 = toroidal edges, 0 = out-of-board cells are dead; sampled at UPDATE entry
wr_en  in  1  host cell write strobe
wr_x  in  LOG_W  write column
wr_y  in  LOG_H  write row
wr_data  in  1  write value
rd_x  in  LOG_W  display read column
rd_y  in  LOG_H  display read row
rd_cell  out  1  combinational board[rd_y][rd_x]
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when any action finishes
gen_count  out  GEN_W  generations since last clear/randomize
pop_count  out  LOG_W+LOG_H+1  live cells in board after last update

Behaviour:
- N = 2^(LOG_W+LOG_H); cell index = {y, x}. Two arrays: board, board_next.
- States: IDLE, INIT, CLEAR, UPDATE, COPY. Reset state: INIT if RESET_INIT=1, else CLEAR. Reset values: done=0, gen_count=0, pop_count=0, all index/timer/accumulator registers 0, LFSR=16'h0001; busy=1 while in reset.
- IDLE request priority, sampled each cycle: clear_req > rand_req > step_req > timer. The winning request moves to its state on the next edge. Lower-priority requests that cycle are dropped, not queued.
- Timer: in IDLE with run=1, counts to UPDATE_INTERVAL-1, then holds. Launches UPDATE when held and frame_sync=1, and clears to 0 on launch. With run=0 it holds its value. Any explicit request also clears the timer.
- INIT: one cell per cycle, board[i] <= lfsr[0]; N cycles. CLEAR: board[i] <= 0; N cycles. Both zero gen_count on completion.
- UPDATE: 9 cycles per cell (8 neighbour-accumulate cycles, order (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1), then 1 write cycle).
  - Write cycle: next = (alive & n==2) | n==3. The neighbour accumulator is 4 bits.
  - wrap_mode=1: coordinates wrap modulo W/H. wrap_mode=0: any out-of-range neighbour contributes 0.
  - Population accumulator counts next-state ones and latches into pop_count at UPDATE end.
  - Duration 9N cycles.
- COPY: board[i] <= board_next[i], 1 cell per cycle, N cycles. gen_count increments (wraps at 2^GEN_W) on the last COPY cycle.
- done pulses for exactly the cycle after the last cell of INIT, CLEAR or COPY, coincident with state=IDLE. step_req accepted at edge k gives done at cycle k+10N.
- Host write: board[wr_y][wr_x] <= wr_data only when state=IDLE and no request wins that cycle; otherwise silently ignored.
- rd_cell reads board asynchronously at all times. During COPY the display may show mixed generations, which is accepted.
- LFSR: 16-bit, shift left, feedback = b15^b13^b12^b10, free-running every cycle.
- Async reset mid-action aborts immediately. Board contents are undefined until the post-reset INIT/CLEAR completes.

Decomposition:
- Package gol_pkg: state enum (IDLE, INIT, CLEAR, UPDATE, COPY), neighbour offset table (8 dx/dy pairs), LFSR seed 16'h0001 and tap mask.
- One sub-module gol_lfsr (16-bit Fibonacci LFSR, async reset to seed, output bit 0).

Test Plan:
- LOG_W=LOG_H=3, RESET_INIT=0: release reset -> busy=1 for 64 cycles, done pulse, board all 0, gen_count=0.
- Blinker, wrap_mode=1: write (3,2),(3,3),(3,4), pulse step_req -> done 640 cycles later; live cells exactly (2,3),(3,3),(4,3); pop_count=3; gen_count=1. A second step restores the vertical line; gen_count=2.
- Corner L-block, wrap_mode=1 vs 0: cells (0,0),(7,0),(0,7) -> wrap: block forms, (7,7) born, pop_count=4. Dead-edge: pop_count=0.
- Priority: assert clear_req, rand_req and step_req in the same IDLE cycle -> CLEAR entered, board 0, gen_count=0. wr_en while busy=1 leaves the target cell unchanged.
- Auto-run: UPDATE_INTERVAL=10, run=1, frame_sync held 0 -> no launch. Raise frame_sync -> UPDATE starts next edge. run=0 -> no further steps.
- Reset mid-UPDATE (cell 20): assert reset -> busy=1, done=0, gen_count=0. After release, INIT runs N cycles, then IDLE.
